ext_pipe_unit: RTL and testbench
================================

Name: ext_pipe_unit

Overview:
- Parametrised, pipelined successor to the single-cycle immediate extender.
- Handles two jobs:
  - immediate extension: sign, zero, load-upper;
  - load-data sub-word extraction plus extension: lb/lbu/lh/lhu/lw, using the byte offset.
- The combinational core is followed by STAGES register stages with valid, stall and flush control.
- Sits between D→E for immediates, or M→W for load data, wherever the pipeline instantiates it.

Parameters:
- DATA_W, 32, result and load-data width; must be 32 or 64.
- IMM_W, 16, immediate field width; must be less than DATA_W.
- STAGES, 1, number of register stages (1..3); equals latency in cycles.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input operands valid this cycle.
- stall  in  1  hold every stage; no advance.
- flush  in  1  clear valid in every stage.
- op  in  4  operation code (ext_defs).
- imm  in  IMM_W  immediate field.
- rdata  in  DATA_W  raw aligned memory word.
- addr_lo  in  $clog2(DATA_W/8)  byte offset within the word.
- out_valid  out  1  result valid, last stage.
- result  out  DATA_W  extended value, last stage.
- misalign  out  1  alignment fault for the op at the last stage.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - all stage valid bits, result registers and misalign registers go to 0 immediately;
  - outputs stay 0 until rst_n rises.
- Op codes:
  - 0 NONE: result 0.
  - 1 SEXT: imm sign-extended to DATA_W.
  - 2 ZEXT: imm zero-extended.
  - 3 HIGH: imm placed at bits [IMM_W+15:16] with zeros below; for DATA_W=64 the upper bits are the sign of imm (MIPS64 lui).
  - 4 LB, 5 LBU: byte at rdata[8*addr_lo +: 8], sign- or zero-extended.
  - 6 LH, 7 LHU: halfword at rdata[8*addr_lo +: 16].
  - 8 LW: word at rdata[8*addr_lo +: 32]; LW is sign-extended when DATA_W=64.
  - 9 LD: full word; legal only when DATA_W=64.
  - Other codes: treated as NONE.
- Alignment faults:
  - The fault conditions are: LH/LHU with addr_lo[0]=1; LW with addr_lo[1:0]≠0; LD with addr_lo≠0; LD when DATA_W=32.
  - On a fault: misalign=1 and result=0.
  - misalign is only meaningful when out_valid=1; it is 0 otherwise.
- Pipeline advance, evaluated at each posedge:
  - If flush=1: all valid bits go to 0; data registers may keep stale values; flush has priority over stall.
  - Else if stall=1: every stage holds its contents; in_valid is ignored that cycle; no input is lost, because the upstream stage also holds.
  - Else: stage0 captures the combinational result together with in_valid, and stage k captures stage k-1.
- Latency:
  - An input accepted at edge N is visible on the outputs after edge N+STAGES-1, i.e. STAGES cycles after presentation, when no stall occurs.
  - Each stall cycle adds one cycle of latency.
- Throughput: one operation per cycle.
- Bubbles: when in_valid=0 the stage valid bit is 0, and result is still the computed value (don't-care).
- Simultaneous events:
  - stall and flush in the same cycle: flush wins.
  - rst_n deassertion coinciding with in_valid: the first capture happens at the first posedge after release.

Decomposition:
- Package/include ext_defs holds:
  - the op code localparams (EXT_NONE..EXT_LD, 4 bits);
  - the width-check macro;
  - default DATA_W/IMM_W.
- Sub-module ext_core: purely combinational (op, imm, rdata, addr_lo) → (value, fault).
- ext_pipe_unit wraps ext_core with a generate-loop register array over STAGES.
- Elaboration check: an $error when STAGES is outside 1..3, or IMM_W ≥ DATA_W.

Test Plan:
- Reset: hold rst_n=0 while driving in_valid=1 and op=SEXT → out_valid=0, result=0, misalign=0; after release with STAGES=2, SEXT imm=16'h8001 → result 32'hFFFF8001 on the 2nd cycle.
- Immediates, STAGES=1, back-to-back:
  - ZEXT 16'h8001 → 32'h00008001;
  - HIGH 16'h1234 → 32'h12340000;
  - each one cycle later; out_valid stays continuously 1.
- Loads with rdata=32'h80FF7F01:
  - LB addr_lo=2 → 32'hFFFFFFFF;
  - LBU addr_lo=3 → 32'h00000080;
  - LH addr_lo=0 → 32'h00007F01;
  - LHU addr_lo=2 → 32'h000080FF;
  - LW addr_lo=0 → 32'h80FF7F01.
- Misalign: LH addr_lo=1 → misalign=1, result=0; LW addr_lo=2 → misalign=1; LD with DATA_W=32 → misalign=1.
- Stall/flush, STAGES=3:
  - issue A,B,C and stall 2 cycles → outputs frozen and A emerges 2 cycles late, in order;
  - assert stall+flush together → out_valid=0 for the next 3 cycles, then new D arrives normally.
- Mid-operation reset: pulse rst_n low between clock edges with valid data in all stages → out_valid drops to 0 asynchronously, and nothing emerges after release.
- DATA_W=64 variant: LW addr_lo=4 on rdata=64'h8000000100000000 → 64'hFFFFFFFF80000001; HIGH 16'h8000 → 64'hFFFFFFFF80000000.

Source files
------------

// File: rtl/ext_defs.sv
// Shared definitions for the extension pipeline: op codes, default widths
// and the width-legality macro used by the elaboration checks.
`ifndef EXT_DEFS_SV
`define EXT_DEFS_SV

`define EXT_WIDTH_OK(dw, iw) ((((dw) == 32) || ((dw) == 64)) && ((iw) < (dw)))

package ext_defs;

  localparam int EXT_DATA_W_DEF = 32;
  localparam int EXT_IMM_W_DEF  = 16;

  localparam logic [3:0] EXT_NONE = 4'd0;
  localparam logic [3:0] EXT_SEXT = 4'd1;
  localparam logic [3:0] EXT_ZEXT = 4'd2;
  localparam logic [3:0] EXT_HIGH = 4'd3;
  localparam logic [3:0] EXT_LB   = 4'd4;
  localparam logic [3:0] EXT_LBU  = 4'd5;
  localparam logic [3:0] EXT_LH   = 4'd6;
  localparam logic [3:0] EXT_LHU  = 4'd7;
  localparam logic [3:0] EXT_LW   = 4'd8;
  localparam logic [3:0] EXT_LD   = 4'd9;

endpackage

`endif

// File: rtl/ext_core.sv
// Combinational extender: immediate sign/zero/upper forms and load-data
// sub-word extraction with alignment fault detection.
module ext_core
  import ext_defs::*;
#(
  parameter int DATA_W = EXT_DATA_W_DEF,
  parameter int IMM_W  = EXT_IMM_W_DEF
) (
  input  logic [3:0]                     op,
  input  logic [IMM_W-1:0]               imm,
  input  logic [DATA_W-1:0]              rdata,
  input  logic [$clog2(DATA_W/8)-1:0]    addr_lo,
  output logic [DATA_W-1:0]              value,
  output logic                           fault
);

  localparam int OFF_W = $clog2(DATA_W/8);
  // MIPS64 lui sign-fills above the shifted immediate; 32-bit zero-fills.
  localparam bit HIGH_SEXT = (DATA_W == 64);

  logic [OFF_W+2:0] shamt;
  logic [7:0]       byte_v;
  logic [15:0]      half_v;
  logic [31:0]      word_v;

  assign shamt  = {addr_lo, 3'b000};
  assign byte_v = 8'(rdata >> shamt);
  assign half_v = 16'(rdata >> shamt);
  assign word_v = 32'(rdata >> shamt);

  always_comb begin
    value = '0;
    fault = 1'b0;
    case (op)
      EXT_SEXT: value = DATA_W'($signed(imm));
      EXT_ZEXT: value = DATA_W'(imm);
      EXT_HIGH: value = HIGH_SEXT ? (DATA_W'($signed(imm)) << 16)
                                  : (DATA_W'(imm) << 16);
      EXT_LB:   value = DATA_W'($signed(byte_v));
      EXT_LBU:  value = DATA_W'(byte_v);
      EXT_LH, EXT_LHU: begin
        if (addr_lo[0]) begin
          fault = 1'b1;
        end else if (op == EXT_LH) begin
          value = DATA_W'($signed(half_v));
        end else begin
          value = DATA_W'(half_v);
        end
      end
      EXT_LW: begin
        if (addr_lo[1:0] != 2'b00) begin
          fault = 1'b1;
        end else begin
          value = DATA_W'($signed(word_v));
        end
      end
      EXT_LD: begin
        // A full-word load only exists on the 64-bit datapath.
        if ((DATA_W == 32) || (addr_lo != '0)) begin
          fault = 1'b1;
        end else begin
          value = rdata;
        end
      end
      default: value = '0;
    endcase
  end

endmodule

// File: rtl/ext_pipe_unit.sv
// Pipelined extender: ext_core followed by STAGES register stages with
// valid, stall and flush control; latency equals STAGES.
module ext_pipe_unit
  import ext_defs::*;
#(
  parameter int DATA_W = EXT_DATA_W_DEF,
  parameter int IMM_W  = EXT_IMM_W_DEF,
  parameter int STAGES = 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  input  logic                           stall,
  input  logic                           flush,
  input  logic [3:0]                     op,
  input  logic [IMM_W-1:0]               imm,
  input  logic [DATA_W-1:0]              rdata,
  input  logic [$clog2(DATA_W/8)-1:0]    addr_lo,
  output logic                           out_valid,
  output logic [DATA_W-1:0]              result,
  output logic                           misalign
);

  if ((STAGES < 1) || (STAGES > 3) || !(`EXT_WIDTH_OK(DATA_W, IMM_W))) begin : g_param_err
    $error("ext_pipe_unit: illegal parameters DATA_W=%0d IMM_W=%0d STAGES=%0d",
           DATA_W, IMM_W, STAGES);
  end

  logic [DATA_W-1:0] core_value;
  logic              core_fault;

  ext_core #(
    .DATA_W (DATA_W),
    .IMM_W  (IMM_W)
  ) u_core (
    .op      (op),
    .imm     (imm),
    .rdata   (rdata),
    .addr_lo (addr_lo),
    .value   (core_value),
    .fault   (core_fault)
  );

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic              v_d;
    logic              f_d;
    logic [DATA_W-1:0] r_d;
    logic              v_q;
    logic              f_q;
    logic [DATA_W-1:0] r_q;

    if (k == 0) begin : g_src
      assign v_d = in_valid;
      assign f_d = core_fault;
      assign r_d = core_value;
    end else begin : g_src
      assign v_d = g_stage[k-1].v_q;
      assign f_d = g_stage[k-1].f_q;
      assign r_d = g_stage[k-1].r_q;
    end

    // Flush only kills valid bits; data may go stale behind a cleared valid.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q <= 1'b0;
        f_q <= 1'b0;
        r_q <= '0;
      end else if (flush) begin
        v_q <= 1'b0;
      end else if (!stall) begin
        v_q <= v_d;
        f_q <= f_d;
        r_q <= r_d;
      end
    end
  end

  assign out_valid = g_stage[STAGES-1].v_q;
  assign result    = g_stage[STAGES-1].r_q;
  assign misalign  = g_stage[STAGES-1].v_q & g_stage[STAGES-1].f_q;

endmodule

// File: tb/tb_ext_pipe_unit.sv
// Directed self-checking bench for ext_pipe_unit: 32-bit instances with
// 1, 2 and 3 stages plus a 64-bit single-stage instance on shared controls.
module tb_ext_pipe_unit;
  import ext_defs::*;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        stall;
  logic        flush;
  logic [3:0]  op;
  logic [15:0] imm;
  logic [31:0] rdata32;
  logic [63:0] rdata64;
  logic [1:0]  addr32;
  logic [2:0]  addr64;

  logic        v1, v2, v3, v64;
  logic        m1, m2, m3, m64;
  logic [31:0] r1, r2, r3;
  logic [63:0] r64;

  int checks = 0;
  int errors = 0;

  ext_pipe_unit #(.DATA_W(32), .IMM_W(16), .STAGES(1)) u_s1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .stall(stall), .flush(flush),
    .op(op), .imm(imm), .rdata(rdata32), .addr_lo(addr32),
    .out_valid(v1), .result(r1), .misalign(m1));

  ext_pipe_unit #(.DATA_W(32), .IMM_W(16), .STAGES(2)) u_s2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .stall(stall), .flush(flush),
    .op(op), .imm(imm), .rdata(rdata32), .addr_lo(addr32),
    .out_valid(v2), .result(r2), .misalign(m2));

  ext_pipe_unit #(.DATA_W(32), .IMM_W(16), .STAGES(3)) u_s3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .stall(stall), .flush(flush),
    .op(op), .imm(imm), .rdata(rdata32), .addr_lo(addr32),
    .out_valid(v3), .result(r3), .misalign(m3));

  ext_pipe_unit #(.DATA_W(64), .IMM_W(16), .STAGES(1)) u_w64 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .stall(stall), .flush(flush),
    .op(op), .imm(imm), .rdata(rdata64), .addr_lo(addr64),
    .out_valid(v64), .result(r64), .misalign(m64));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [3:0] o,
                               input logic [15:0] i, input logic [1:0] a);
    in_valid = v;
    op       = o;
    imm      = i;
    addr32   = a;
  endtask

  // Advance one edge and land 1 time unit after it, away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [3:0]  o;
    logic [1:0]  a;
    logic [31:0] exp_r;
    logic        exp_m;
    string       tag;
  } load_vec_t;

  load_vec_t loads[$];

  initial begin
    loads.push_back('{EXT_LB,   2'd2, 32'hFFFFFFFF, 1'b0, "lb_a2"});
    loads.push_back('{EXT_LBU,  2'd3, 32'h00000080, 1'b0, "lbu_a3"});
    loads.push_back('{EXT_LH,   2'd0, 32'h00007F01, 1'b0, "lh_a0"});
    loads.push_back('{EXT_LHU,  2'd2, 32'h000080FF, 1'b0, "lhu_a2"});
    loads.push_back('{EXT_LW,   2'd0, 32'h80FF7F01, 1'b0, "lw_a0"});
    loads.push_back('{EXT_LH,   2'd1, 32'h00000000, 1'b1, "lh_a1_mis"});
    loads.push_back('{EXT_LW,   2'd2, 32'h00000000, 1'b1, "lw_a2_mis"});
    loads.push_back('{EXT_LD,   2'd0, 32'h00000000, 1'b1, "ld_w32_mis"});
    loads.push_back('{EXT_NONE, 2'd0, 32'h00000000, 1'b0, "none"});
    loads.push_back('{4'hF,     2'd0, 32'h00000000, 1'b0, "undef_op"});

    rst_n   = 1'b1;
    stall   = 1'b0;
    flush   = 1'b0;
    rdata32 = 32'h80FF7F01;
    rdata64 = 64'h8000000100000000;
    addr64  = 3'd0;
    applyStimulus(1'b1, EXT_SEXT, 16'h8001, 2'd0);
    #1 rst_n = 1'b0;

    step();
    step();
    checkOutput("rst_valid_s2", {63'd0, v2}, 64'd0);
    checkOutput("rst_result_s2", {32'd0, r2}, 64'd0);
    checkOutput("rst_misalign_s2", {63'd0, m2}, 64'd0);
    checkOutput("rst_valid_s1", {63'd0, v1}, 64'd0);

    rst_n = 1'b1;
    step();
    checkOutput("rel_s2_not_yet", {63'd0, v2}, 64'd0);
    checkOutput("sext_s1", {32'd0, r1}, 64'h00000000FFFF8001);
    applyStimulus(1'b1, EXT_ZEXT, 16'h8001, 2'd0);
    step();
    checkOutput("sext_s2_valid", {63'd0, v2}, 64'd1);
    checkOutput("sext_s2", {32'd0, r2}, 64'h00000000FFFF8001);
    checkOutput("zext_s1", {32'd0, r1}, 64'h0000000000008001);
    checkOutput("zext_s1_valid", {63'd0, v1}, 64'd1);
    applyStimulus(1'b1, EXT_HIGH, 16'h1234, 2'd0);
    step();
    checkOutput("high_s1", {32'd0, r1}, 64'h0000000012340000);
    checkOutput("high_s1_valid", {63'd0, v1}, 64'd1);
    checkOutput("zext_s2", {32'd0, r2}, 64'h0000000000008001);

    foreach (loads[n]) begin
      applyStimulus(1'b1, loads[n].o, 16'h0000, loads[n].a);
      step();
      checkOutput({loads[n].tag, "_valid"}, {63'd0, v1}, 64'd1);
      checkOutput(loads[n].tag, {32'd0, r1}, {32'd0, loads[n].exp_r});
      checkOutput({loads[n].tag, "_misalign"}, {63'd0, m1}, {63'd0, loads[n].exp_m});
    end

    applyStimulus(1'b0, EXT_LH, 16'h0000, 2'd1);
    step();
    checkOutput("bubble_valid", {63'd0, v1}, 64'd0);
    checkOutput("bubble_misalign", {63'd0, m1}, 64'd0);

    applyStimulus(1'b1, EXT_LW, 16'h0000, 2'd0);
    addr64 = 3'd4;
    step();
    checkOutput("w64_lw_a4", r64, 64'hFFFFFFFF80000001);
    checkOutput("w64_lw_a4_misalign", {63'd0, m64}, 64'd0);
    applyStimulus(1'b1, EXT_HIGH, 16'h8000, 2'd0);
    step();
    checkOutput("w64_high", r64, 64'hFFFFFFFF80000000);
    applyStimulus(1'b1, EXT_LD, 16'h0000, 2'd0);
    addr64 = 3'd0;
    step();
    checkOutput("w64_ld_a0", r64, 64'h8000000100000000);
    checkOutput("w64_ld_a0_misalign", {63'd0, m64}, 64'd0);
    addr64 = 3'd4;
    step();
    checkOutput("w64_ld_a4_misalign", {63'd0, m64}, 64'd1);
    checkOutput("w64_ld_a4_result", r64, 64'd0);

    applyStimulus(1'b0, EXT_SEXT, 16'h0000, 2'd0);
    repeat (3) step();
    checkOutput("s3_drained", {63'd0, v3}, 64'd0);
    applyStimulus(1'b1, EXT_SEXT, 16'h0001, 2'd0);
    step();
    applyStimulus(1'b1, EXT_SEXT, 16'h0002, 2'd0);
    step();
    stall = 1'b1;
    applyStimulus(1'b1, EXT_SEXT, 16'h0003, 2'd0);
    step();
    checkOutput("stall1_valid", {63'd0, v3}, 64'd0);
    step();
    checkOutput("stall2_valid", {63'd0, v3}, 64'd0);
    stall = 1'b0;
    step();
    checkOutput("a_late_valid", {63'd0, v3}, 64'd1);
    checkOutput("a_late", {32'd0, r3}, 64'd1);
    stall = 1'b1;
    applyStimulus(1'b0, EXT_SEXT, 16'h0000, 2'd0);
    step();
    checkOutput("frozen_valid", {63'd0, v3}, 64'd1);
    checkOutput("frozen_result", {32'd0, r3}, 64'd1);
    stall = 1'b0;
    step();
    checkOutput("b_out", {32'd0, r3}, 64'd2);
    checkOutput("b_valid", {63'd0, v3}, 64'd1);
    step();
    checkOutput("c_out", {32'd0, r3}, 64'd3);
    step();
    checkOutput("after_c_valid", {63'd0, v3}, 64'd0);

    applyStimulus(1'b1, EXT_SEXT, 16'h0004, 2'd0);
    step();
    applyStimulus(1'b1, EXT_SEXT, 16'h0005, 2'd0);
    step();
    applyStimulus(1'b1, EXT_SEXT, 16'h0006, 2'd0);
    step();
    checkOutput("prefill_valid", {63'd0, v3}, 64'd1);
    stall = 1'b1;
    flush = 1'b1;
    applyStimulus(1'b1, EXT_SEXT, 16'h0007, 2'd0);
    step();
    checkOutput("flush_c1_valid", {63'd0, v3}, 64'd0);
    stall = 1'b0;
    flush = 1'b0;
    applyStimulus(1'b1, EXT_SEXT, 16'h0008, 2'd0);
    step();
    checkOutput("flush_c2_valid", {63'd0, v3}, 64'd0);
    applyStimulus(1'b0, EXT_SEXT, 16'h0000, 2'd0);
    step();
    checkOutput("flush_c3_valid", {63'd0, v3}, 64'd0);
    step();
    checkOutput("d_valid", {63'd0, v3}, 64'd1);
    checkOutput("d_out", {32'd0, r3}, 64'd8);

    applyStimulus(1'b1, EXT_SEXT, 16'h0009, 2'd0);
    repeat (3) step();
    checkOutput("prereset_valid", {63'd0, v3}, 64'd1);
    applyStimulus(1'b0, EXT_SEXT, 16'h0000, 2'd0);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_reset_valid", {63'd0, v3}, 64'd0);
    checkOutput("async_reset_result", {32'd0, r3}, 64'd0);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      checkOutput("post_reset_empty", {63'd0, v3}, 64'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
